// File: rtl/shift_cmd_queue_if.sv
// Handshake bundle for shift_cmd_queue: command input, shifter drive/return,
// result output and status counters.
interface shift_cmd_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
);
  logic                     inValid;
  logic                     inReady;
  logic [15:0]              inNum;
  logic [3:0]               inAmt;
  logic                     inLr;

  logic [15:0]              shNum;
  logic [3:0]               shAmt;
  logic                     shLr;
  logic [15:0]              shResult;

  logic                     outValid;
  logic                     outReady;
  logic [15:0]              outNum;

  logic [$clog2(DEPTH):0]   count;
  logic [CW-1:0]            doneCnt;

  modport slave (
    input  inValid, inNum, inAmt, inLr, shResult, outReady,
    output inReady, shNum, shAmt, shLr, outValid, outNum, count, doneCnt
  );

  modport master (
    output inValid, inNum, inAmt, inLr, shResult, outReady,
    input  inReady, shNum, shAmt, shLr, outValid, outNum, count, doneCnt
  );
endinterface

// File: rtl/shift_cmd_queue.sv
// Command FIFO feeding an external combinational rotator, with a registered
// result holding stage and a completed-result counter.
module shift_cmd_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input logic             clk,
  input logic             n_rst,
  shift_cmd_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  amt;
    logic        lr;
  } cmd_t;

  typedef enum logic [0:0] {StEmpty, StHold} out_state_e;

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  out_state_e      state_q, state_d;
  logic [15:0]     out_num_q, out_num_d;
  logic [CW-1:0]   done_cnt_q, done_cnt_d;

  logic            in_ready;
  logic            not_empty;
  logic            out_valid;
  logic            push;
  logic            pop;
  logic            consume;
  cmd_t            head;

  // inReady looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready  = (count_q != CntW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign out_valid = (state_q == StHold);
  assign push      = bus.inValid & in_ready;
  assign pop       = not_empty & (~out_valid | bus.outReady);
  assign consume   = out_valid & bus.outReady;

  // Storage carries no reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= cmd_t'{num: bus.inNum, amt: bus.inAmt, lr: bus.inLr};
    end
  end

  always_comb begin
    head = not_empty ? mem_q[rptr_q] : '0;
  end

  assign bus.shNum = head.num;
  assign bus.shAmt = head.amt;
  assign bus.shLr  = head.lr;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    out_num_d = out_num_q;
    unique case (state_q)
      StEmpty: begin
        if (pop) begin
          state_d   = StHold;
          out_num_d = bus.shResult;
        end
      end
      StHold: begin
        if (pop) begin
          out_num_d = bus.shResult;
        end else if (bus.outReady) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (consume) begin
      done_cnt_d = done_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      state_q    <= StEmpty;
      out_num_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      out_num_q  <= out_num_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.outNum   = out_num_q;
  assign bus.count    = count_q;
  assign bus.doneCnt  = done_cnt_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed bench for shift_cmd_queue; the bench itself plays the rotator.
module tb_shift_cmd_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_cmd_queue_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

  function automatic logic [15:0] rot(input logic [15:0] n, input logic [3:0] a, input logic lr);
    logic [31:0] d;
    logic [31:0] s;
    d = {n, n};
    if (lr) begin
      s = d >> a;
      return s[15:0];
    end
    s = d << a;
    return s[31:16];
  endfunction

  assign bus.shResult = rot(bus.shNum, bus.shAmt, bus.shLr);

  shift_cmd_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] n, input logic [3:0] a, input logic l);
    bus.inValid = v;
    bus.inNum   = n;
    bus.inAmt   = a;
    bus.inLr    = l;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    bus.outReady = 1'b0;
    tick;
    tick;
    n_rst = 1'b1;
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%b want=0", bus.outValid); end
    checks++; if (bus.outNum !== 16'h0) begin failures++; $display("FAIL reset_outNum got=%h want=0000", bus.outNum); end
    checks++; if (bus.doneCnt !== 16'd0) begin failures++; $display("FAIL reset_doneCnt got=%0d want=0", bus.doneCnt); end
    checks++; if (bus.shNum !== 16'h0) begin failures++; $display("FAIL reset_shNum got=%h want=0000", bus.shNum); end
    checks++; if (bus.inReady !== 1'b1) begin failures++; $display("FAIL reset_inReady got=%b want=1", bus.inReady); end
  endtask

  task automatic test_single(input string tag, input logic [15:0] exp_done);
    bus.outReady = 1'b1;
    drive(1'b1, 16'h1234, 4'd4, 1'b1);
    tick;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL %s_count got=%0d want=1", tag, bus.count); end
    checks++; if ({bus.shNum, bus.shAmt, bus.shLr} !== {16'h1234, 4'd4, 1'b1}) begin
      failures++; $display("FAIL %s_sh got=%h/%0d/%b want=1234/4/1", tag, bus.shNum, bus.shAmt, bus.shLr); end
    checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL %s_early_valid got=%b want=0", tag, bus.outValid); end
    tick;
    checks++; if (bus.outValid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b want=1", tag, bus.outValid); end
    checks++; if (bus.outNum !== 16'h4123) begin failures++; $display("FAIL %s_outNum got=%h want=4123", tag, bus.outNum); end
    tick;
    checks++; if (bus.doneCnt !== exp_done) begin failures++; $display("FAIL %s_doneCnt got=%0d want=%0d", tag, bus.doneCnt, exp_done); end
    checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL %s_drained got=%b want=0", tag, bus.outValid); end
  endtask

  task automatic test_back_to_back;
    bus.outReady = 1'b1;
    drive(1'b1, 16'h1234, 4'd4, 1'b0);
    tick;
    drive(1'b1, 16'hBEEF, 4'd0, 1'b1);
    tick;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    checks++; if ({bus.outValid, bus.outNum} !== {1'b1, 16'h2341}) begin
      failures++; $display("FAIL b2b_first got=%b/%h want=1/2341", bus.outValid, bus.outNum); end
    tick;
    checks++; if ({bus.outValid, bus.outNum} !== {1'b1, 16'hBEEF}) begin
      failures++; $display("FAIL b2b_second got=%b/%h want=1/beef", bus.outValid, bus.outNum); end
    tick;
    checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b want=0", bus.outValid); end
    checks++; if (bus.doneCnt !== 16'd3) begin failures++; $display("FAIL b2b_doneCnt got=%0d want=3", bus.doneCnt); end
  endtask

  task automatic test_full;
    logic [15:0] n [6];
    logic [3:0]  a [6];
    logic        l [6];
    logic [15:0] exp [6];
    int          idx;
    logic        pushed;
    for (int i = 0; i < 6; i++) begin
      n[i]   = 16'h1111 * 16'(i + 1) ^ 16'h8000;
      a[i]   = 4'(i + 1);
      l[i]   = i[0];
      exp[i] = rot(n[i], a[i], l[i]);
    end
    bus.outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, n[i], a[i], l[i]);
      tick;
    end
    drive(1'b1, n[5], a[5], l[5]);
    checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d want=4", bus.count); end
    checks++; if (bus.inReady !== 1'b0) begin failures++; $display("FAIL full_inReady got=%b want=0", bus.inReady); end
    checks++; if ({bus.outValid, bus.outNum} !== {1'b1, exp[0]}) begin
      failures++; $display("FAIL full_head got=%b/%h want=1/%h", bus.outValid, bus.outNum, exp[0]); end
    tick;
    tick;
    checks++; if ({bus.inReady, bus.count} !== {1'b0, 3'd4}) begin
      failures++; $display("FAIL full_stall got=%b/%0d want=0/4", bus.inReady, bus.count); end
    bus.outReady = 1'b1;
    idx = 0;
    for (int c = 0; c < 12 && idx < 6; c++) begin
      checks++; if (bus.outValid !== 1'b1) begin failures++; $display("FAIL full_drain_valid got=%b want=1 at=%0d", bus.outValid, idx); end
      if (bus.outValid === 1'b1) begin
        checks++; if (bus.outNum !== exp[idx]) begin
          failures++; $display("FAIL full_drain_data got=%h want=%h at=%0d", bus.outNum, exp[idx], idx); end
        idx++;
      end
      pushed = bus.inValid & bus.inReady;
      tick;
      if (pushed) bus.inValid = 1'b0;
    end
    checks++; if (idx !== 6) begin failures++; $display("FAIL full_drain_count got=%0d want=6", idx); end
    checks++; if (bus.inValid !== 1'b0) begin failures++; $display("FAIL full_sixth_push got=%b want=0", bus.inValid); end
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL full_end_count got=%0d want=0", bus.count); end
    checks++; if (bus.doneCnt !== 16'd9) begin failures++; $display("FAIL full_doneCnt got=%0d want=9", bus.doneCnt); end
  endtask

  task automatic test_stream;
    logic [15:0] q [$];
    logic [15:0] n;
    logic [3:0]  a;
    logic        l;
    logic [15:0] want;
    bus.outReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      n = 16'($urandom);
      a = 4'($urandom_range(0, 15));
      l = 1'($urandom_range(0, 1));
      drive(1'b1, n, a, l);
      q.push_back(rot(n, a, l));
      if (bus.outValid === 1'b1) begin
        want = q.pop_front();
        checks++; if (bus.outNum !== want) begin failures++; $display("FAIL stream_data got=%h want=%h cyc=%0d", bus.outNum, want, c); end
      end
      tick;
      checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL stream_count got=%0d want=1 cyc=%0d", bus.count, c); end
    end
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    for (int c = 0; c < 6 && q.size() > 0; c++) begin
      if (bus.outValid === 1'b1) begin
        want = q.pop_front();
        checks++; if (bus.outNum !== want) begin failures++; $display("FAIL stream_tail got=%h want=%h", bus.outNum, want); end
      end
      tick;
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL stream_left got=%0d want=0", q.size()); end
    checks++; if ({bus.outValid, bus.count} !== {1'b0, 3'd0}) begin
      failures++; $display("FAIL stream_idle got=%b/%0d want=0/0", bus.outValid, bus.count); end
    checks++; if (bus.doneCnt !== 16'd29) begin failures++; $display("FAIL stream_doneCnt got=%0d want=29", bus.doneCnt); end
  endtask

  task automatic test_backpressure;
    bus.outReady = 1'b0;
    drive(1'b1, 16'hA5A5, 4'd3, 1'b0);
    tick;
    drive(1'b1, 16'h00FF, 4'd8, 1'b1);
    tick;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checks++; if ({bus.outValid, bus.outNum, bus.count} !== {1'b1, 16'h2D2D, 3'd1}) begin
        failures++; $display("FAIL bp_hold got=%b/%h/%0d want=1/2d2d/1 cyc=%0d", bus.outValid, bus.outNum, bus.count, c); end
      checks++; if (bus.shNum !== 16'h00FF) begin failures++; $display("FAIL bp_head got=%h want=00ff", bus.shNum); end
      tick;
    end
    bus.outReady = 1'b1;
    tick;
    checks++; if ({bus.outValid, bus.outNum, bus.count} !== {1'b1, 16'hFF00, 3'd0}) begin
      failures++; $display("FAIL bp_release got=%b/%h/%0d want=1/ff00/0", bus.outValid, bus.outNum, bus.count); end
    tick;
    checks++; if (bus.doneCnt !== 16'd31) begin failures++; $display("FAIL bp_doneCnt got=%0d want=31", bus.doneCnt); end
  endtask

  task automatic test_mid_reset;
    bus.outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hC000 + 16'(i), 4'(i + 1), 1'b0);
      tick;
    end
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    checks++; if ({bus.outValid, bus.count} !== {1'b1, 3'd3}) begin
      failures++; $display("FAIL mrst_pre got=%b/%0d want=1/3", bus.outValid, bus.count); end
    n_rst = 1'b0;
    tick;
    n_rst = 1'b1;
    checks++; if ({bus.count, bus.outValid, bus.outNum, bus.doneCnt} !== {3'd0, 1'b0, 16'h0, 16'd0}) begin
      failures++; $display("FAIL mrst_state got=%0d/%b/%h/%0d want=0/0/0000/0", bus.count, bus.outValid, bus.outNum, bus.doneCnt); end
    checks++; if ({bus.shNum, bus.shAmt, bus.shLr} !== 21'h0) begin
      failures++; $display("FAIL mrst_sh got=%h/%0d/%b want=0/0/0", bus.shNum, bus.shAmt, bus.shLr); end
    test_single("post_reset", 16'd1);
  endtask

  initial begin
    bus.outReady = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    test_reset;
    test_single("single", 16'd1);
    test_back_to_back;
    test_full;
    test_stream;
    test_backpressure;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
